// File: rtl/cva5_types.sv
// Shared writeback types: one unit's completion request and the packet consumed by ID management.
package cva5_types;

   localparam int unsigned LOG2_MAX_IDS = 3;
   localparam int unsigned XLEN = 32;

   typedef logic [LOG2_MAX_IDS-1:0] id_t;

   typedef struct packed {
      logic              done;
      id_t               id;
      logic [XLEN-1:0]   rd;
   } unit_wb_req_t;

   typedef struct packed {
      logic              valid;
      id_t               id;
      logic [XLEN-1:0]   data;
   } wb_packet_t;

endpackage

// File: rtl/round_robin_grant.sv
// Round-robin one-hot grant: requests at or above ptr win first, then the search wraps to 0.
module round_robin_grant #(
   parameter int unsigned N = 4,
   localparam int unsigned PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             any
);

   logic [2*N-1:0] req2;
   logic [2*N-1:0] masked;
   logic           found;
   int unsigned    sel;

   always_comb begin
      req2   = {req, req};
      masked = '0;
      // The upper copy keeps every request, so the lowest set bit above ptr is the wrapped winner.
      for (int i = 0; i < 2 * N; i++) begin
         if (i >= int'(ptr)) masked[i] = req2[i];
      end

      found = 1'b0;
      sel   = 0;
      for (int i = 0; i < 2 * N; i++) begin
         if (masked[i] && !found) begin
            sel   = i;
            found = 1'b1;
         end
      end
      if (sel >= N) sel = sel - N;

      grant_idx = PTR_W'(sel);
      any       = |req;
      grant     = '0;
      if (any) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/wb_group_arbiter.sv
// Shares one writeback port among several out-of-order units; registers the granted result and
// counts cycles in which more than one unit was waiting.
module wb_group_arbiter
   import cva5_types::*;
#(
   parameter int unsigned NUM_UNITS = 4,
   parameter int unsigned ID_W      = LOG2_MAX_IDS,
   parameter int unsigned DATA_W    = XLEN,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_UNITS-1:0]        unit_done,
   input  logic [NUM_UNITS*ID_W-1:0]   unit_id,
   input  logic [NUM_UNITS*DATA_W-1:0] unit_rd,
   output logic [NUM_UNITS-1:0]        unit_ack,
   output logic                        wb_valid,
   output logic [ID_W-1:0]             wb_id,
   output logic [DATA_W-1:0]           wb_data,
   output logic [CNT_W-1:0]            conflict_count
);

   localparam int unsigned PTR_W = $clog2(NUM_UNITS);

   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [PTR_W-1:0]     grant_idx;
   logic [NUM_UNITS-1:0] grant;
   logic                 any;
   logic [ID_W-1:0]      sel_id;
   logic [DATA_W-1:0]    sel_data;
   logic                 conflict;

   round_robin_grant #(
      .N(NUM_UNITS)
   ) u_rr (
      .req      (unit_done),
      .ptr      (ptr_q),
      .grant    (grant),
      .grant_idx(grant_idx),
      .any      (any)
   );

   assign unit_ack = rst ? '0 : grant;
   assign conflict = $countones(unit_done) > 1;

   always_comb begin
      ptr_d    = ptr_q;
      sel_id   = '0;
      sel_data = '0;
      if (any) begin
         ptr_d = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (grant[i]) begin
            sel_id   = sel_id | unit_id[i*ID_W +: ID_W];
            sel_data = sel_data | unit_rd[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q          <= '0;
         wb_valid       <= 1'b0;
         wb_id          <= '0;
         wb_data        <= '0;
         conflict_count <= '0;
      end else begin
         ptr_q    <= ptr_d;
         wb_valid <= any;
         if (any) begin
            wb_id   <= sel_id;
            wb_data <= sel_data;
         end
         if (conflict && (conflict_count != '1)) conflict_count <= conflict_count + CNT_W'(1);
      end
   end

   a_ack_onehot: assert property (@(posedge clk) $onehot0(unit_ack));
   a_ack_done:   assert property (@(posedge clk) (unit_ack & ~unit_done) == '0);

   for (genvar i = 0; i < NUM_UNITS; i++) begin : g_id_stable
      a_id_stable: assert property (@(posedge clk) disable iff (rst)
         (unit_done[i] && !unit_ack[i]) |=> $stable(unit_id[i*ID_W +: ID_W]));
   end

endmodule
